reservation_station: RTL and testbench

Tomasulo reservation station: the receiving end of the common data bus. It accepts issued instructions, snoops every CDB broadcast to resolve pending source tags, dispatches ready instructions to its functional unit, and frees an entry when that entry's own tag appears on the CDB. Each functional-unit group (ADD/SUB, MUL/DIV) instantiates one station, selected by `UNIT_TYPE`.

---
 rtl/reservation_station.sv | 196 +++++++++++++++++++
 tb/tb_reservation_station.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/reservation_station.sv
// Tomasulo reservation station for one functional-unit group.
// Accepts issued instructions and snoops the common data bus (CDB) to resolve
// pending source tags. It dispatches the lowest ready entry to the functional
// unit. An entry is freed when its own tag {UNIT_TYPE, index} is broadcast
// while it is executing.
// Ports:
//   Clock, Resetn            - rising-edge clock, async active-low reset
//   Issue*                   - issue request, operands, producer tags/pend bits;
//                              IssueReady/IssueLabel report the next free entry
//   cdbIn                    - CDB word: [22] valid, [21:19] tag, [15:0] data
//   Disp*                    - dispatch handshake and selected instruction
//   BusyMask                 - per-entry "not FREE" flags
// All outputs are decoded from registered entry state only.
module reservation_station #(
  parameter int unsigned NUM_ENTRIES = 2,
  parameter int unsigned UNIT_TYPE   = 0
) (
  input  logic                   Clock,
  input  logic                   Resetn,
  input  logic                   IssueValid,
  output logic                   IssueReady,
  output logic [1:0]             IssueLabel,
  input  logic [1:0]             IssueOp,
  input  logic [2:0]             IssueDest,
  input  logic [15:0]            IssueVj,
  input  logic [15:0]            IssueVk,
  input  logic                   IssueQjPend,
  input  logic                   IssueQkPend,
  input  logic [2:0]             IssueQj,
  input  logic [2:0]             IssueQk,
  input  logic [23:0]            cdbIn,
  output logic                   DispValid,
  input  logic                   DispReady,
  output logic [1:0]             DispOp,
  output logic [15:0]            DispA,
  output logic [15:0]            DispB,
  output logic [1:0]             DispLabel,
  output logic [2:0]             DispDest,
  output logic [NUM_ENTRIES-1:0] BusyMask
);

  localparam int unsigned OP_W   = 2;
  localparam int unsigned REG_W  = 3;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned TAG_W  = 3;
  localparam int unsigned LBL_W  = 2;

  typedef enum logic [1:0] {ST_FREE, ST_WAIT, ST_READY, ST_EXEC} state_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] vj;
    logic [DATA_W-1:0] vk;
    logic [TAG_W-1:0]  qj;
    logic [TAG_W-1:0]  qk;
    logic              pj;
    logic              pk;
  } entry_t;

  state_t state_q [NUM_ENTRIES];
  state_t state_d [NUM_ENTRIES];
  entry_t ent_q   [NUM_ENTRIES];
  entry_t ent_d   [NUM_ENTRIES];

  // CDB field split; the destination-register field and bit 23 play no part in matching
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              unused_cdb;

  assign cdb_valid  = cdbIn[22];
  assign cdb_tag    = cdbIn[21:19];
  assign cdb_data   = cdbIn[15:0];
  assign unused_cdb = ^{cdbIn[23], cdbIn[18:16]};

  function automatic logic cdb_hit(input logic v, input logic [TAG_W-1:0] bus_tag,
                                   input logic [TAG_W-1:0] tag);
    return v && (bus_tag == tag);
  endfunction

  logic             free_found;
  logic [LBL_W-1:0] free_idx;
  logic             rdy_found;
  logic [LBL_W-1:0] rdy_idx;
  logic             issue_fire;
  logic             disp_fire;

  // Lowest FREE entry: target of the next issue
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (!free_found && state_q[i] == ST_FREE) begin
        free_found = 1'b1;
        free_idx   = LBL_W'(i);
      end
    end
  end

  // Lowest READY entry drives the dispatch port; zeros when nothing is ready
  always_comb begin
    rdy_found = 1'b0;
    rdy_idx   = '0;
    DispOp    = '0;
    DispA     = '0;
    DispB     = '0;
    DispDest  = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (!rdy_found && state_q[i] == ST_READY) begin
        rdy_found = 1'b1;
        rdy_idx   = LBL_W'(i);
        DispOp    = ent_q[i].op;
        DispA     = ent_q[i].vj;
        DispB     = ent_q[i].vk;
        DispDest  = ent_q[i].dest;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      BusyMask[i] = (state_q[i] != ST_FREE);
    end
  end

  assign IssueReady = free_found;
  assign IssueLabel = free_idx;
  assign DispValid  = rdy_found;
  assign DispLabel  = rdy_idx;
  assign issue_fire = IssueValid && free_found;
  assign disp_fire  = rdy_found && DispReady;

  // Per-entry next state: issue with bypass, operand snooping, dispatch, free
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      state_d[i] = state_q[i];
      ent_d[i]   = ent_q[i];
      case (state_q[i])
        ST_FREE: begin
          if (issue_fire && free_idx == LBL_W'(i)) begin
            ent_d[i].op   = IssueOp;
            ent_d[i].dest = IssueDest;
            ent_d[i].qj   = IssueQj;
            ent_d[i].qk   = IssueQk;
            ent_d[i].vj   = (IssueQjPend && cdb_hit(cdb_valid, cdb_tag, IssueQj)) ? cdb_data : IssueVj;
            ent_d[i].vk   = (IssueQkPend && cdb_hit(cdb_valid, cdb_tag, IssueQk)) ? cdb_data : IssueVk;
            ent_d[i].pj   = IssueQjPend && !cdb_hit(cdb_valid, cdb_tag, IssueQj);
            ent_d[i].pk   = IssueQkPend && !cdb_hit(cdb_valid, cdb_tag, IssueQk);
            state_d[i]    = (ent_d[i].pj || ent_d[i].pk) ? ST_WAIT : ST_READY;
          end
        end
        ST_WAIT: begin
          if (ent_q[i].pj && cdb_hit(cdb_valid, cdb_tag, ent_q[i].qj)) begin
            ent_d[i].vj = cdb_data;
            ent_d[i].pj = 1'b0;
          end
          if (ent_q[i].pk && cdb_hit(cdb_valid, cdb_tag, ent_q[i].qk)) begin
            ent_d[i].vk = cdb_data;
            ent_d[i].pk = 1'b0;
          end
          if (!ent_d[i].pj && !ent_d[i].pk) begin
            state_d[i] = ST_READY;
          end
        end
        ST_READY: begin
          if (disp_fire && rdy_idx == LBL_W'(i)) begin
            state_d[i] = ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cdb_hit(cdb_valid, cdb_tag, {1'(UNIT_TYPE), LBL_W'(i)})) begin
            state_d[i] = ST_FREE;
          end
        end
        default: state_d[i] = ST_FREE;
      endcase
    end
  end

  // Entry state registers
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        state_q[i] <= ST_FREE;
        ent_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        state_q[i] <= state_d[i];
        ent_q[i]   <= ent_d[i];
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench for reservation_station (NUM_ENTRIES=2, UNIT_TYPE=0).
// A cycle table holds per-cycle inputs and the expected outputs after the edge.
// Expected dispatches are queued when issued and compared at each handshake.
module tb_reservation_station;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        IssueValid;
  logic        IssueReady;
  logic [1:0]  IssueLabel;
  logic [1:0]  IssueOp;
  logic [2:0]  IssueDest;
  logic [15:0] IssueVj, IssueVk;
  logic        IssueQjPend, IssueQkPend;
  logic [2:0]  IssueQj, IssueQk;
  logic [23:0] cdbIn;
  logic        DispValid;
  logic        DispReady;
  logic [1:0]  DispOp;
  logic [15:0] DispA, DispB;
  logic [1:0]  DispLabel;
  logic [2:0]  DispDest;
  logic [1:0]  BusyMask;

  reservation_station #(.NUM_ENTRIES(2), .UNIT_TYPE(0)) dut (
    .Clock(Clock), .Resetn(Resetn),
    .IssueValid(IssueValid), .IssueReady(IssueReady), .IssueLabel(IssueLabel),
    .IssueOp(IssueOp), .IssueDest(IssueDest), .IssueVj(IssueVj), .IssueVk(IssueVk),
    .IssueQjPend(IssueQjPend), .IssueQkPend(IssueQkPend), .IssueQj(IssueQj), .IssueQk(IssueQk),
    .cdbIn(cdbIn), .DispValid(DispValid), .DispReady(DispReady),
    .DispOp(DispOp), .DispA(DispA), .DispB(DispB), .DispLabel(DispLabel), .DispDest(DispDest),
    .BusyMask(BusyMask)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  lbl;
    logic [2:0]  dest;
  } disp_t;

  typedef struct {
    logic        iv;
    logic [1:0]  op;
    logic [2:0]  dest;
    logic [15:0] vj, vk;
    logic        qjp;
    logic [2:0]  qj;
    logic        qkp;
    logic [2:0]  qk;
    logic [23:0] cdb;
    logic        drdy;
    logic        push;
    logic [15:0] sb_a, sb_b;
    logic [1:0]  sb_l;
    logic [1:0]  busy;
    logic        irdy;
    logic [1:0]  ilbl;
    logic        dv;
    logic [15:0] da, db;
    logic [1:0]  dl;
  } vec_t;

  int    pass_cnt = 0;
  int    check_cnt = 0;
  disp_t sbq[$];
  vec_t  vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [23:0] cdb(input logic v, input logic [2:0] tag, input logic [15:0] d);
    return {1'b0, v, tag, 3'b000, d};
  endfunction

  function automatic vec_t mk(
      input logic iv, input logic [1:0] op, input logic [2:0] dest,
      input logic [15:0] vj, input logic [15:0] vk,
      input logic qjp, input logic [2:0] qj, input logic qkp, input logic [2:0] qk,
      input logic [23:0] c, input logic drdy,
      input logic push, input logic [15:0] sb_a, input logic [15:0] sb_b, input logic [1:0] sb_l,
      input logic [1:0] busy, input logic irdy, input logic [1:0] ilbl,
      input logic dv, input logic [15:0] da, input logic [15:0] db, input logic [1:0] dl);
    vec_t v;
    v.iv = iv; v.op = op; v.dest = dest; v.vj = vj; v.vk = vk;
    v.qjp = qjp; v.qj = qj; v.qkp = qkp; v.qk = qk; v.cdb = c; v.drdy = drdy;
    v.push = push; v.sb_a = sb_a; v.sb_b = sb_b; v.sb_l = sb_l;
    v.busy = busy; v.irdy = irdy; v.ilbl = ilbl; v.dv = dv; v.da = da; v.db = db; v.dl = dl;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    IssueValid = v.iv; IssueOp = v.op; IssueDest = v.dest; IssueVj = v.vj; IssueVk = v.vk;
    IssueQjPend = v.qjp; IssueQj = v.qj; IssueQkPend = v.qkp; IssueQk = v.qk;
    cdbIn = v.cdb; DispReady = v.drdy;
    if (v.push) sbq.push_back({v.op, v.sb_a, v.sb_b, v.sb_l, v.dest});
  endtask

  task automatic idle();
    IssueValid = 0; IssueOp = 0; IssueDest = 0; IssueVj = 0; IssueVk = 0;
    IssueQjPend = 0; IssueQj = 0; IssueQkPend = 0; IssueQk = 0;
    cdbIn = 0; DispReady = 0;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 64'(BusyMask), 64'd0);
    chk({tag, "_irdy"}, 64'(IssueReady), 64'd1);
    chk({tag, "_ilbl"}, 64'(IssueLabel), 64'd0);
    chk({tag, "_dv"}, 64'(DispValid), 64'd0);
    chk({tag, "_disp"}, 64'({DispOp, DispA, DispB, DispLabel, DispDest}), 64'd0);
  endtask

  // Dispatch scoreboard: every accepted dispatch must match the oldest expectation
  always @(negedge Clock) begin
    if (Resetn && DispValid && DispReady) begin
      if (sbq.size() == 0) begin
        check_cnt++;
        $display("FAIL sb_unexpected: got dispatch label %0d expected none", DispLabel);
      end else begin
        chk("sb_dispatch", 64'({DispOp, DispA, DispB, DispLabel, DispDest}), 64'(sbq.pop_front()));
      end
    end
  end

  initial begin
    vec_t v;
    //         iv op dest vj       vk       qjp qj    qkp qk    cdb                        drdy push sb_a     sb_b     sbl busy  irdy ilbl dv da       db       dl
    vecs.push_back(mk(1, 1, 2, 16'h0005, 16'h0003, 0, 3'd0, 0, 3'd0, 24'd0,                  0, 1, 16'h0005, 16'h0003, 0, 2'b01, 1, 1, 1, 16'h0005, 16'h0003, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 3'd0, 0, 3'd0, 24'd0,                  1, 0, 16'h0000, 16'h0000, 0, 2'b01, 1, 1, 0, 16'h0000, 16'h0000, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 3'd0, 0, 3'd0, cdb(1, 3'b000, 16'h8),  0, 0, 16'h0000, 16'h0000, 0, 2'b00, 1, 0, 0, 16'h0000, 16'h0000, 0));
    vecs.push_back(mk(1, 2, 3, 16'h0000, 16'h0007, 1, 3'b101, 0, 3'd0, 24'd0,                0, 1, 16'h0010, 16'h0007, 0, 2'b01, 1, 1, 0, 16'h0000, 16'h0000, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 3'd0, 0, 3'd0, cdb(1, 3'b101, 16'h10), 0, 0, 16'h0000, 16'h0000, 0, 2'b01, 1, 1, 1, 16'h0010, 16'h0007, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 3'd0, 0, 3'd0, 24'd0,                  1, 0, 16'h0000, 16'h0000, 0, 2'b01, 1, 1, 0, 16'h0000, 16'h0000, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 3'd0, 0, 3'd0, cdb(1, 3'b000, 16'h1),  0, 0, 16'h0000, 16'h0000, 0, 2'b00, 1, 0, 0, 16'h0000, 16'h0000, 0));
    vecs.push_back(mk(1, 3, 4, 16'h0011, 16'h0000, 0, 3'd0, 1, 3'b100, cdb(1, 3'b100, 16'h42), 0, 1, 16'h0011, 16'h0042, 0, 2'b01, 1, 1, 1, 16'h0011, 16'h0042, 0));
    vecs.push_back(mk(1, 0, 5, 16'h0001, 16'h0002, 0, 3'd0, 0, 3'd0, 24'd0,                  1, 1, 16'h0001, 16'h0002, 1, 2'b11, 0, 0, 1, 16'h0001, 16'h0002, 1));
    vecs.push_back(mk(1, 1, 6, 16'h0009, 16'h0009, 0, 3'd0, 0, 3'd0, 24'd0,                  0, 0, 16'h0000, 16'h0000, 0, 2'b11, 0, 0, 1, 16'h0001, 16'h0002, 1));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 3'd0, 0, 3'd0, cdb(1, 3'b000, 16'h2),  0, 0, 16'h0000, 16'h0000, 0, 2'b10, 1, 0, 1, 16'h0001, 16'h0002, 1));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 3'd0, 0, 3'd0, 24'd0,                  1, 0, 16'h0000, 16'h0000, 0, 2'b10, 1, 0, 0, 16'h0000, 16'h0000, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 3'd0, 0, 3'd0, cdb(1, 3'b001, 16'h3),  0, 0, 16'h0000, 16'h0000, 0, 2'b00, 1, 0, 0, 16'h0000, 16'h0000, 0));
    vecs.push_back(mk(1, 1, 1, 16'h0000, 16'h0004, 1, 3'b101, 0, 3'd0, 24'd0,                0, 1, 16'h0077, 16'h0004, 0, 2'b01, 1, 1, 0, 16'h0000, 16'h0000, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 3'd0, 0, 3'd0, cdb(0, 3'b101, 16'h99), 0, 0, 16'h0000, 16'h0000, 0, 2'b01, 1, 1, 0, 16'h0000, 16'h0000, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 3'd0, 0, 3'd0, cdb(0, 3'b000, 16'h99), 0, 0, 16'h0000, 16'h0000, 0, 2'b01, 1, 1, 0, 16'h0000, 16'h0000, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 3'd0, 0, 3'd0, cdb(1, 3'b000, 16'h55), 0, 0, 16'h0000, 16'h0000, 0, 2'b01, 1, 1, 0, 16'h0000, 16'h0000, 0));
    vecs.push_back(mk(1, 2, 6, 16'h0000, 16'h0000, 1, 3'b101, 1, 3'b101, cdb(1, 3'b101, 16'h77), 0, 1, 16'h0077, 16'h0077, 1, 2'b11, 0, 0, 1, 16'h0077, 16'h0004, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 3'd0, 0, 3'd0, 24'd0,                  1, 0, 16'h0000, 16'h0000, 0, 2'b11, 0, 0, 1, 16'h0077, 16'h0077, 1));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 3'd0, 0, 3'd0, cdb(1, 3'b000, 16'h4),  1, 0, 16'h0000, 16'h0000, 0, 2'b10, 1, 0, 0, 16'h0000, 16'h0000, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 3'd0, 0, 3'd0, cdb(1, 3'b001, 16'h5),  0, 0, 16'h0000, 16'h0000, 0, 2'b00, 1, 0, 0, 16'h0000, 16'h0000, 0));

    Resetn = 1'b0;
    idle();
    repeat (2) @(posedge Clock);
    #1;
    chk_idle("reset");
    Resetn = 1'b1;
    tick();
    chk_idle("post_reset");

    foreach (vecs[k]) begin
      v = vecs[k];
      drive(v);
      tick();
      chk($sformatf("v%0d_busy", k), 64'(BusyMask), 64'(v.busy));
      chk($sformatf("v%0d_irdy", k), 64'(IssueReady), 64'(v.irdy));
      chk($sformatf("v%0d_ilbl", k), 64'(IssueLabel), 64'(v.ilbl));
      chk($sformatf("v%0d_dv", k), 64'(DispValid), 64'(v.dv));
      chk($sformatf("v%0d_dab", k), 64'({DispA, DispB, DispLabel}), 64'({v.da, v.db, v.dl}));
    end
    idle();
    tick();

    // Entry in WAIT resolves its two operands on different cycles
    v = mk(1, 3, 7, 16'h0, 16'h0, 1, 3'b110, 1, 3'b111, 24'd0, 0, 1, 16'h000A, 16'h000B, 0,
           2'b00, 0, 0, 0, 16'h0, 16'h0, 0);
    drive(v);
    tick();
    idle();
    chk("w1_busy", 64'(BusyMask), 64'b01);
    chk("w1_dv", 64'(DispValid), 64'd0);
    cdbIn = cdb(1, 3'b110, 16'h000A);
    tick();
    chk("w1_half_dv", 64'(DispValid), 64'd0);
    cdbIn = cdb(1, 3'b111, 16'h000B);
    tick();
    chk("w1_ready", 64'({DispValid, DispA, DispB, DispLabel}), 64'({1'b1, 16'h000A, 16'h000B, 2'd0}));

    // Second entry waits on the same tag for both operands
    v = mk(1, 1, 2, 16'h0, 16'h0, 1, 3'b110, 1, 3'b110, 24'd0, 0, 1, 16'h000C, 16'h000C, 1,
           2'b00, 0, 0, 0, 16'h0, 16'h0, 0);
    drive(v);
    tick();
    idle();
    chk("w2_full", 64'({BusyMask, IssueReady}), 64'({2'b11, 1'b0}));
    cdbIn = cdb(1, 3'b110, 16'h000C);
    tick();
    chk("w2_prio", 64'({DispValid, DispLabel}), 64'({1'b1, 2'd0}));
    cdbIn = 24'd0;
    DispReady = 1'b1;
    tick();
    chk("w2_both", 64'({DispValid, DispA, DispB, DispLabel, DispDest}),
        64'({1'b1, 16'h000C, 16'h000C, 2'd1, 3'd2}));
    tick();
    DispReady = 1'b0;
    chk("w2_exec", 64'({BusyMask, DispValid}), 64'({2'b11, 1'b0}));

    // Asynchronous reset in the middle of a cycle with both entries executing
    #2;
    Resetn = 1'b0;
    #1;
    chk_idle("midreset");
    sbq.delete();
    tick();
    Resetn = 1'b1;
    tick();
    tick();
    chk_idle("after_midreset");
    chk("sb_drained", 64'(sbq.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
